// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter for a single-ported, fixed-latency memory.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break in IDLE instead of fixed D priority.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [ADDR_W-1:0] if_data,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_dport_q, grant_dport_d;
    logic              store_q, store_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              issue;
    logic              pick_dport;
    logic [ADDR_W-1:0] rdata_instr;

    // Fetched words land in an ADDR_W-wide register; resize the memory word to fit.
    generate
        if (ADDR_W > DATA_W) begin : g_rdata_ext
            assign rdata_instr = {{(ADDR_W - DATA_W){1'b0}}, mem_rdata};
        end else begin : g_rdata_trunc
            assign rdata_instr = mem_rdata[ADDR_W-1:0];
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dport_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dport_q <= 1'b0;
        end else if (issue) begin
            last_dport_q <= pick_dport;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_dport_d = grant_dport_q;
        store_d       = store_q;
        first_d       = first_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_data_d     = if_data_q;
        d_rdata_d     = d_rdata_q;
        issue         = 1'b0;
        pick_dport    = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    issue = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    pick_dport = (if_req && d_req) ? !last_dport_q : d_req;
`else
                    pick_dport = d_req;
`endif
                end
            end
            BUSY: begin
                first_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!store_q) begin
                        if (grant_dport_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_data_d = rdata_instr;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // The grantee still holds its req this cycle, so only the other port may be issued.
                if (grant_dport_q ? if_req : d_req) begin
                    issue      = 1'b1;
                    pick_dport = !grant_dport_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d       = BUSY;
            cnt_d         = CNT_INIT;
            grant_dport_d = pick_dport;
            store_d       = pick_dport && d_wr;
            first_d       = 1'b1;
            mem_addr_d    = pick_dport ? d_addr : if_addr;
            if (pick_dport && d_wr) begin
                mem_wdata_d = d_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_dport_q <= 1'b0;
            store_q       <= 1'b0;
            first_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_data_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_dport_q <= grant_dport_d;
            store_q       <= store_d;
            first_q       <= first_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_data_q     <= if_data_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == BUSY);
    assign mem_wr    = mem_en && first_q && store_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_data   = if_data_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = (state_q == RESP) && !grant_dport_q;
    assign d_ack     = (state_q == RESP) && grant_dport_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-4 instance for the main scenarios and a latency-1 instance.
// Expected acks are queued at issue time and matched by per-instance monitors on the falling edge.
module tb_mem_arbiter;

    localparam int L1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_d;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    // Latency-4 instance signals
    logic        if_req1, if_ack1, d_req1, d_wr1, d_ack1, mem_en1, mem_wr1, busy1;
    logic [15:0] if_addr1, if_data1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    // Latency-1 instance signals
    logic        if_req2, if_ack2, d_req2, d_wr2, d_ack2, mem_en2, mem_wr2, busy2;
    logic [15:0] if_addr2, if_data2, d_addr2, d_wdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2;

    mem_arbiter #(.MEM_LATENCY(L1), .ADDR_W(16), .DATA_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_data(if_data1), .if_ack(if_ack1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(16), .DATA_W(16)) dut2 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2), .if_data(if_data2), .if_ack(if_ack2),
        .d_req(d_req2), .d_wr(d_wr2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_rdata(d_rdata2), .d_ack(d_ack2),
        .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    // Memory model for the latency-4 instance: data is only valid in the L-th enable cycle.
    bit [15:0] mem_store [0:65535];
    bit        mem_valid [0:65535];
    logic [3:0] run1;

    function automatic logic [15:0] base_data(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h5A5A);
    endfunction

    always @(posedge clk) begin
        if (rst || !mem_en1) run1 <= 4'd0;
        else                 run1 <= run1 + 4'd1;
        if (mem_wr1) begin
            mem_store[mem_addr1] <= mem_wdata1;
            mem_valid[mem_addr1] <= 1'b1;
        end
    end

    assign mem_rdata1 = (mem_en1 && run1 == 4'(L1 - 1))
                        ? (mem_valid[mem_addr1] ? mem_store[mem_addr1] : base_data(mem_addr1))
                        : 16'hDEAD;
    assign mem_rdata2 = mem_en2 ? (mem_addr2 ^ 16'h5A5A) : 16'hDEAD;

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitors: pop one expectation per ack.
    always @(negedge clk) begin
        if (if_ack1 || d_ack1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ack1_unexpected: got if_ack=%b d_ack=%b, expected no ack (cycle %0d)",
                         if_ack1, d_ack1, cyc);
            end else begin
                e1 = q1.pop_front();
                check("ack1_onehot", 32'(if_ack1 & d_ack1), 32'd0);
                check("ack1_port", 32'(d_ack1), 32'(e1.is_d));
                check("ack1_data", 32'(e1.is_d ? d_rdata1 : if_data1), 32'(e1.data));
                check("ack1_cycle", cyc, e1.at);
                $display("L4 ack port=%s data=%h cycle=%0d", d_ack1 ? "D" : "I",
                         d_ack1 ? d_rdata1 : if_data1, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (if_ack2 || d_ack2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ack2_unexpected: got if_ack=%b d_ack=%b, expected no ack (cycle %0d)",
                         if_ack2, d_ack2, cyc);
            end else begin
                e2 = q2.pop_front();
                check("ack2_onehot", 32'(if_ack2 & d_ack2), 32'd0);
                check("ack2_port", 32'(d_ack2), 32'(e2.is_d));
                check("ack2_data", 32'(e2.is_d ? d_rdata2 : if_data2), 32'(e2.data));
                check("ack2_cycle", cyc, e2.at);
                $display("L1 ack port=%s data=%h cycle=%0d", d_ack2 ? "D" : "I",
                         d_ack2 ? d_rdata2 : if_data2, cyc);
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl1"}, 32'({busy1, mem_en1, mem_wr1, if_ack1, d_ack1}), 32'd0);
        check({tag, "_data1"}, {if_data1, d_rdata1}, 32'd0);
        check({tag, "_mem1"}, {mem_addr1, mem_wdata1}, 32'd0);
        check({tag, "_ctrl2"}, 32'({busy2, mem_en2, mem_wr2, if_ack2, d_ack2}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int c1;
        int ack_cnt;
        bit first_is_d;

        rst = 1'b1;
        if_req1 = 1'b0; if_addr1 = '0; d_req1 = 1'b0; d_wr1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
        if_req2 = 1'b0; if_addr2 = '0; d_req2 = 1'b0; d_wr2 = 1'b0; d_addr2 = '0; d_wdata2 = '0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single fetch
        c0 = cyc;
        q1.push_back('{1'b0, 16'hA5A5, c0 + 5});
        if_req1 = 1'b1; if_addr1 = 16'h0010;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("s1_mem_en", 32'(mem_en1), 32'(i <= 4));
            if (i <= 4) check("s1_mem_addr", 32'(mem_addr1), 32'h0010);
            check("s1_busy", 32'(busy1), 32'(i <= 5));
            if (i == 6) if_req1 = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Simultaneous I + D load: D first, I issued straight from RESP
        c0 = cyc;
        q1.push_back('{1'b1, 16'h585A, c0 + 5});
        q1.push_back('{1'b0, 16'h5A7A, c0 + 10});
        d_req1 = 1'b1; d_wr1 = 1'b0; d_addr1 = 16'h0200;
        if_req1 = 1'b1; if_addr1 = 16'h0020;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 6) begin
                check("s2_i_issue_en", 32'(mem_en1), 32'd1);
                check("s2_i_issue_addr", 32'(mem_addr1), 32'h0020);
                d_req1 = 1'b0;
            end
            if (i == 10) check("s2_d_rdata_hold", 32'(d_rdata1), 32'h585A);
            if (i == 11) if_req1 = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Store then load of the same address
        c0 = cyc;
        q1.push_back('{1'b1, 16'h585A, c0 + 5});
        d_req1 = 1'b1; d_wr1 = 1'b1; d_addr1 = 16'h0300; d_wdata1 = 16'h1234;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("s3_mem_wr", 32'(mem_wr1), 32'(i == 1));
            if (i == 1) check("s3_mem_wdata", 32'(mem_wdata1), 32'h1234);
            if (i == 6) begin
                d_wr1 = 1'b0;
                q1.push_back('{1'b1, 16'h1234, c0 + 11});
            end
            if (i == 12) d_req1 = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset in the second BUSY cycle of a fetch
        c0 = cyc;
        if_req1 = 1'b1; if_addr1 = 16'h0040;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("s4_midreset");
        rst = 1'b0;
        if_req1 = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack_cnt += int'(if_ack1);
        end
        check("s4_no_ack", ack_cnt, 0);
        c1 = cyc;
        q1.push_back('{1'b0, 16'h5A1E, c1 + 5});
        if_req1 = 1'b1; if_addr1 = 16'h0044;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) if_req1 = 1'b0;
        end
        repeat (2) @(negedge clk);

        // D-only access, gap, then simultaneous requests
        c0 = cyc;
        q1.push_back('{1'b1, 16'h5F5A, c0 + 5});
        d_req1 = 1'b1; d_wr1 = 1'b0; d_addr1 = 16'h0500;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) d_req1 = 1'b0;
        end
        repeat (3) @(negedge clk);
        c1 = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        q1.push_back('{1'b0, 16'h5A3A, c1 + 5});
        q1.push_back('{1'b1, 16'h5C5A, c1 + 10});
        first_is_d = 1'b0;
`else
        q1.push_back('{1'b1, 16'h5C5A, c1 + 5});
        q1.push_back('{1'b0, 16'h5A3A, c1 + 10});
        first_is_d = 1'b1;
`endif
        if_req1 = 1'b1; if_addr1 = 16'h0060;
        d_req1 = 1'b1; d_addr1 = 16'h0600;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 6) begin
                if (first_is_d) d_req1 = 1'b0;
                else            if_req1 = 1'b0;
            end
            if (i == 11) begin
                if_req1 = 1'b0;
                d_req1  = 1'b0;
            end
        end
        repeat (2) @(negedge clk);

        // Latency 1: two requesters alternating back to back
        c0 = cyc;
        q2.push_back('{1'b1, 16'h5D5A, c0 + 2});
        q2.push_back('{1'b0, 16'h5A2A, c0 + 4});
        q2.push_back('{1'b1, 16'h5D5B, c0 + 6});
        q2.push_back('{1'b0, 16'h5A2B, c0 + 8});
        if_req2 = 1'b1; if_addr2 = 16'h0070;
        d_req2 = 1'b1; d_wr2 = 1'b0; d_addr2 = 16'h0700;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 3) d_addr2 = 16'h0701;
            if (i == 5) if_addr2 = 16'h0071;
            if (i == 7) d_req2 = 1'b0;
            if (i == 9) if_req2 = 1'b0;
        end
        repeat (3) @(negedge clk);

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
